// File: rtl/block_vec_seq.sv
// Stimulus sequencer and response capture for the 2-input/2-select block cell.
// Define BLOCK_VEC_SEQ_CHECK_EN to include the golden cell model and mismatch counter.
module block_vec_seq #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [7:0]  SEED        = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       o0_in,
    input  logic       o1_in,
    output logic       i0,
    output logic       i1,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       done,
    output logic [7:0] signature,
    output logic [4:0] o0_ones,
    output logic [4:0] o1_ones,
    output logic [4:0] mismatch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_r;
    logic [3:0] vec_r;
    logic [3:0] hold_cnt_r;
    logic       busy_r;
    logic       done_r;
    logic [7:0] sig_r;
    logic [4:0] o0_ones_r;
    logic [4:0] o1_ones_r;
    logic       sample_s;
    logic       accept_s;

    // One MISR step: shift in the feedback tap, then fold in the two responses.
    function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic o1, input logic o0);
        logic fb;
        fb = sig[7] ^ sig[5] ^ sig[4] ^ sig[3];
        return {sig[6:0], fb} ^ {6'b000000, o1, o0};
    endfunction

    // Sample and start-acceptance qualifiers
    always_comb begin
        sample_s = 1'b0;
        accept_s = 1'b0;
        if (state_r == ST_DRIVE) begin
            sample_s = (hold_cnt_r == HOLD_LAST);
        end else begin
            sample_s = 1'b0;
        end
        if (state_r == ST_IDLE) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Sequencer FSM with registered vector, status and capture results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            vec_r      <= 4'd0;
            hold_cnt_r <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sig_r      <= SEED;
            o0_ones_r  <= 5'd0;
            o1_ones_r  <= 5'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    vec_r      <= 4'd0;
                    hold_cnt_r <= 4'd0;
                    busy_r     <= 1'b0;
                    if (accept_s) begin
                        sig_r     <= SEED;
                        o0_ones_r <= 5'd0;
                        o1_ones_r <= 5'd0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_DRIVE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (sample_s) begin
                        sig_r      <= misr_step(sig_r, o1_in, o0_in);
                        o0_ones_r  <= o0_ones_r + 5'(o0_in);
                        o1_ones_r  <= o1_ones_r + 5'(o1_in);
                        hold_cnt_r <= 4'd0;
                        // Last vector sampled: leave the cell inputs at zero while done pulses.
                        if (vec_r == 4'd15) begin
                            vec_r   <= 4'd0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            vec_r <= vec_r + 4'd1;
                        end
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    vec_r      <= 4'd0;
                    hold_cnt_r <= 4'd0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    vec_r      <= 4'd0;
                    hold_cnt_r <= 4'd0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BLOCK_VEC_SEQ_CHECK_EN
    logic [4:0] mismatch_r;
    logic [1:0] golden_s;

    // Reference cell: returns {O1, O0} for vector {I0, I1, S0, S1}.
    function automatic logic [1:0] golden_cell(input logic [3:0] v);
        logic a;
        logic b;
        logic c;
        a = v[0] | v[3];
        b = v[1] & v[2];
        c = a ^ b;
        case (v[1:0])
            2'b00:   return {a & b, c};
            2'b01:   return {c, c};
            2'b10:   return {a & b, a | b};
            2'b11:   return {c, a | b};
            default: return 2'b00;
        endcase
    endfunction

    // Expected cell response for the vector currently driven
    always_comb begin
        golden_s = 2'b00;
        golden_s = golden_cell(vec_r);
    end

    // Mismatch counter, cleared on accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_r <= 5'd0;
        end else if (accept_s) begin
            mismatch_r <= 5'd0;
        end else if (sample_s && (golden_s != {o1_in, o0_in})) begin
            mismatch_r <= mismatch_r + 5'd1;
        end else begin
            mismatch_r <= mismatch_r;
        end
    end

    assign mismatch_cnt = mismatch_r;
`else
    assign mismatch_cnt = 5'd0;
`endif

    assign i0        = vec_r[3];
    assign i1        = vec_r[2];
    assign s0        = vec_r[1];
    assign s1        = vec_r[0];
    assign busy      = busy_r;
    assign done      = done_r;
    assign signature = sig_r;
    assign o0_ones   = o0_ones_r;
    assign o1_ones   = o1_ones_r;

endmodule

// File: tb/tb_block_vec_seq.sv
// Bench for block_vec_seq: a stubbed/real block cell feeds two instances (H=2 SEED=00, H=1 SEED=A5).
module tb_block_vec_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [1:0] mode;
    logic       sel;

    logic       i0_a, i1_a, s0_a, s1_a, busy_a, done_a, o0_a, o1_a;
    logic [7:0] sig_a;
    logic [4:0] o0c_a, o1c_a, mm_a;
    logic       i0_b, i1_b, s0_b, s1_b, busy_b, done_b, o0_b, o1_b;
    logic [7:0] sig_b;
    logic [4:0] o0c_b, o1c_b, mm_b;

    int total = 0;
    int bad   = 0;

    block_vec_seq #(.HOLD_CYCLES(2), .SEED(8'h00)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .o0_in(o0_a), .o1_in(o1_a),
        .i0(i0_a), .i1(i1_a), .s0(s0_a), .s1(s1_a), .busy(busy_a), .done(done_a),
        .signature(sig_a), .o0_ones(o0c_a), .o1_ones(o1c_a), .mismatch_cnt(mm_a)
    );

    block_vec_seq #(.HOLD_CYCLES(1), .SEED(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .o0_in(o0_b), .o1_in(o1_b),
        .i0(i0_b), .i1(i1_b), .s0(s0_b), .s1(s1_b), .busy(busy_b), .done(done_b),
        .signature(sig_b), .o0_ones(o0c_b), .o1_ones(o1c_b), .mismatch_cnt(mm_b)
    );

    // Behavioural block cell, returns {O1, O0} for {I0, I1, S0, S1}
    function automatic logic [1:0] cell_fn(input logic [3:0] v);
        logic ci0, ci1, cs0, cs1, a, b, c;
        {ci0, ci1, cs0, cs1} = v;
        a = cs1 | ci0;
        b = cs0 & ci1;
        c = a ^ b;
        case ({cs0, cs1})
            2'b00:   return {a & b, c};
            2'b01:   return {c, c};
            2'b10:   return {a & b, a | b};
            default: return {c, a | b};
        endcase
    endfunction

    function automatic logic [1:0] stub_fn(input logic [1:0] m, input logic [3:0] v);
        case (m)
            2'd0:    return cell_fn(v);
            2'd1:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    assign {o1_a, o0_a} = stub_fn(mode, {i0_a, i1_a, s0_a, s1_a});
    assign {o1_b, o0_b} = stub_fn(mode, {i0_b, i1_b, s0_b, s1_b});

    logic [3:0] vec_m;
    logic       busy_m, done_m;
    logic [7:0] sig_m;
    logic [4:0] o0c_m, o1c_m, mm_m;

    always_comb begin
        if (sel) begin
            vec_m = {i0_b, i1_b, s0_b, s1_b}; busy_m = busy_b; done_m = done_b;
            sig_m = sig_b; o0c_m = o0c_b; o1c_m = o1c_b; mm_m = mm_b;
        end else begin
            vec_m = {i0_a, i1_a, s0_a, s1_a}; busy_m = busy_a; done_m = done_a;
            sig_m = sig_a; o0c_m = o0c_a; o1c_m = o1c_a; mm_m = mm_a;
        end
    end

    typedef struct {
        logic [7:0] sig;
        int         o0;
        int         o1;
        int         mm;
        int         lat;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic       sel;
        logic [1:0] mode;
        bit         keep;
        int         o0;
        int         o1;
        int         mm_on;
        int         sig;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // Independent model of one complete run
    function automatic exp_t model_run(input logic [7:0] seed, input logic [1:0] m, input int h);
        exp_t e;
        logic [1:0] r;
        logic fb;
        e.sig = seed; e.o0 = 0; e.o1 = 0; e.mm = 0; e.lat = 16 * h + 1;
        for (int v = 0; v < 16; v++) begin
            r  = stub_fn(m, 4'(v));
            fb = e.sig[7] ^ e.sig[5] ^ e.sig[4] ^ e.sig[3];
            e.sig = {e.sig[6:0], fb} ^ {6'b000000, r};
            e.o0 += int'(r[0]);
            e.o1 += int'(r[1]);
            if (r != cell_fn(4'(v))) e.mm++;
        end
        return e;
    endfunction

    task automatic run_one(input vec_t t);
        exp_t e, got;
        int   h, c, dones;
        logic [7:0] seed;
        sel  = t.sel;
        mode = t.mode;
        h    = t.sel ? 1 : 2;
        seed = t.sel ? 8'hA5 : 8'h00;
        e    = model_run(seed, t.mode, h);
        if (t.sig >= 0) e.sig = 8'(t.sig);
        e.o0 = t.o0;
        e.o1 = t.o1;
`ifdef BLOCK_VEC_SEQ_CHECK_EN
        e.mm = t.mm_on;
`else
        e.mm = 0;
`endif
        @(negedge clk);
        drive_start(1'b1);
        sb_q.push_back(e);
        c = 0; dones = 0;
        got = e;
        while (c < 16 * h + 6) begin
            @(negedge clk);
            c++;
            if (!t.keep || c >= 16 * h - 1) drive_start(1'b0);
            if (c <= 16 * h) begin
                chk("busy_run", 32'(busy_m), 32'd1);
                chk("vec_seq", 32'(vec_m), 32'((c - 1) / h));
            end else begin
                chk("busy_after", 32'(busy_m), 32'd0);
            end
            if (done_m) begin
                dones++;
                chk("done_cycle", c, 16 * h + 1);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    chk("signature", 32'(sig_m), 32'(got.sig));
                    chk("o0_ones", 32'(o0c_m), got.o0);
                    chk("o1_ones", 32'(o1c_m), got.o1);
                    chk("mismatch_cnt", 32'(mm_m), got.mm);
                end else begin
                    chk("scoreboard_empty", 32'(sb_q.size()), 32'd1);
                end
            end
        end
        chk("done_pulses", dones, 1);
        chk("sig_hold", 32'(sig_m), 32'(e.sig));
        chk("o0_hold", 32'(o0c_m), e.o0);
        sb_q.delete();
    endtask

    vec_t tbl[7];

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 2'd0; sel = 1'b0;
        tbl[0] = '{1'b0, 2'd0, 1'b0, 13, 7, 0, -1};
        tbl[1] = '{1'b0, 2'd1, 1'b0, 16, 0, 10, 32'h39};
        tbl[2] = '{1'b0, 2'd0, 1'b1, 13, 7, 0, -1};
        tbl[3] = '{1'b0, 2'd2, 1'b0, 0, 0, 13, 32'h00};
        tbl[4] = '{1'b0, 2'd0, 1'b0, 13, 7, 0, -1};
        tbl[5] = '{1'b1, 2'd0, 1'b0, 13, 7, 0, -1};
        tbl[6] = '{1'b1, 2'd2, 1'b0, 0, 0, 13, -1};

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_busy", 32'(busy_m), 32'd0);
            chk("rst_done", 32'(done_m), 32'd0);
            chk("rst_vec", 32'(vec_m), 32'd0);
            chk("rst_sig", 32'(sig_m), s == 0 ? 32'h00 : 32'hA5);
            chk("rst_counts", 32'({o0c_m, o1c_m, mm_m}), 32'd0);
        end
        rst = 1'b0;

        for (int k = 0; k < 4; k++) run_one(tbl[k]);

        // Reset during vector 7, first hold cycle
        sel = 1'b0; mode = 2'd0;
        @(negedge clk);
        drive_start(1'b1);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) drive_start(1'b0);
        end
        chk("pre_rst_vec", 32'(vec_m), 32'd7);
        chk("pre_rst_o0", 32'(o0c_m), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy_m), 32'd0);
        chk("mid_rst_vec", 32'(vec_m), 32'd0);
        chk("mid_rst_done", 32'(done_m), 32'd0);
        chk("mid_rst_sig", 32'(sig_m), 32'h00);
        chk("mid_rst_counts", 32'({o0c_m, o1c_m}), 32'd0);
        begin
            int dn;
            dn = 0;
            repeat (40) begin
                @(negedge clk);
                if (done_m) dn++;
            end
            chk("no_done_after_rst", dn, 0);
        end

        for (int k = 4; k < 7; k++) run_one(tbl[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
